// File: rtl/uart_receiver.sv
// 8N1 UART receiver sampling on a 16x clock-enable; reports the byte on a sticky rdy, plus framing error and overrun.
// Latency: rdy rises at the mid-stop sample, 2 clk of synchroniser plus 152 clken pulses after the start edge; no backpressure, overrun flags a lost byte.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       rx_busy,
    output logic       ferr,
    output logic       overrun
);

    localparam logic [3:0] LP_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LP_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t     r_state, w_state_nxt;
    logic       r_sync1, r_sync2;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_bit, w_bit_nxt;
    logic       r_armed, w_armed_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_dout, w_dout_nxt;
    logic       r_rdy, w_rdy_nxt;
    logic       r_ferr, w_ferr_nxt;
    logic       r_ovr, w_ovr_nxt;
    logic       w_rx;

    assign w_rx = r_sync2;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_armed_nxt = r_armed;
        w_shift_nxt = r_shift;
        w_dout_nxt  = r_dout;
        w_rdy_nxt   = r_rdy;
        w_ferr_nxt  = r_ferr;
        w_ovr_nxt   = r_ovr;

        if (rdy_clr) begin
            w_rdy_nxt = 1'b0;
            w_ovr_nxt = 1'b0;
        end

        if (clken) begin
            unique case (r_state)
                IDLE: begin
                    // Needs a high line before each start so a held break cannot retrigger.
                    if (w_rx) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        w_state_nxt = START;
                        w_cnt_nxt   = 4'd0;
                        w_armed_nxt = 1'b0;
                    end
                end
                START: begin
                    if (r_cnt == LP_MID) begin
                        w_cnt_nxt = 4'd0;
                        if (!w_rx) begin
                            w_state_nxt = DATA;
                            w_bit_nxt   = 3'd0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (r_cnt == LP_LAST) begin
                        w_cnt_nxt   = 4'd0;
                        w_shift_nxt = {w_rx, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_bit_nxt = r_bit + 3'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == LP_LAST) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = IDLE;
                        if (w_rx) begin
                            w_dout_nxt = r_shift;
                            w_rdy_nxt  = 1'b1;
                            w_ferr_nxt = 1'b0;
                            // A same-cycle acknowledge consumed the old byte, so nothing is lost.
                            if (r_rdy && !rdy_clr) begin
                                w_ovr_nxt = 1'b1;
                            end
                        end else begin
                            w_ferr_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= 4'd0;
            r_bit   <= 3'd0;
            r_armed <= 1'b0;
            r_shift <= 8'h00;
            r_dout  <= 8'h00;
            r_rdy   <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_armed <= w_armed_nxt;
            r_shift <= w_shift_nxt;
            r_dout  <= w_dout_nxt;
            r_rdy   <= w_rdy_nxt;
            r_ferr  <= w_ferr_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    assign dout    = r_dout;
    assign rdy     = r_rdy;
    assign rx_busy = (r_state != IDLE);
    assign ferr    = r_ferr;
    assign overrun = r_ovr;

endmodule
